// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam logic MODE_ADDRESSED  = 1'b0;
    localparam logic MODE_SEQUENTIAL = 1'b1;

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register for a single demux channel.
module demux_out_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // NOTE: the data register is reset and zeroed on drain so an empty lane always reads 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux_1_n_stream.sv
// 1-to-N valid/ready stream demultiplexer: addressed or burst round-robin routing into per-channel slots.
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_OUT      = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int BURST_LEN  = 1
) (
    input  logic                        DEMUXN_CLOCK_50,
    input  logic                        DEMUXN_RESET_InHigh,
    input  logic                        DEMUXN_Clear,
    input  logic                        DEMUXN_En,
    input  logic                        DEMUXN_Mode,
    input  logic [SEL_WIDTH-1:0]        DEMUXN_Sel,
    input  logic [DATA_WIDTH-1:0]       DEMUXN_Data_in,
    input  logic                        DEMUXN_Valid_in,
    output logic                        DEMUXN_Ready_out,
    output logic [N_OUT*DATA_WIDTH-1:0] DEMUXN_Data_out,
    output logic [N_OUT-1:0]            DEMUXN_Valid_out,
    input  logic [N_OUT-1:0]            DEMUXN_Ready_in,
    output logic [SEL_WIDTH-1:0]        DEMUXN_Ptr,
    output logic                        DEMUXN_Wrap,
    output logic                        DEMUXN_SelErr
);

    localparam int                     CNT_WIDTH = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;
    localparam logic [SEL_WIDTH-1:0]   LAST_PTR  = SEL_WIDTH'(N_OUT - 1);
    localparam logic [CNT_WIDTH-1:0]   LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [SEL_WIDTH:0]     N_OUT_EXT = (SEL_WIDTH + 1)'(N_OUT);

    if (SEL_WIDTH < clog2(N_OUT)) begin : g_bad_sel_width
        $error("SEL_WIDTH is too narrow to address N_OUT channels");
    end

    logic [SEL_WIDTH-1:0] r_ptr;
    logic [CNT_WIDTH-1:0] r_beat;
    logic                 r_wrap;

    logic [SEL_WIDTH-1:0] w_target;
    logic [N_OUT-1:0]     w_target_hot;
    logic [N_OUT-1:0]     w_valid;
    logic [N_OUT-1:0]     w_load;
    logic                 w_target_busy;
    logic                 w_sel_err;
    logic                 w_ready;
    logic                 w_accept;

    assign w_target = (DEMUXN_Mode == MODE_SEQUENTIAL) ? r_ptr : DEMUXN_Sel;

    // An out-of-range select decodes to no channel, so it never looks busy.
    always_comb begin
        w_target_hot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_target_hot[k] = (w_target == SEL_WIDTH'(k));
        end
    end

    assign w_sel_err     = (DEMUXN_Mode == MODE_ADDRESSED) && DEMUXN_Valid_in
                           && ({1'b0, DEMUXN_Sel} >= N_OUT_EXT);
    assign w_target_busy = |(w_target_hot & w_valid & ~DEMUXN_Ready_in);
    assign w_ready       = DEMUXN_En && !DEMUXN_Clear && !w_sel_err && !w_target_busy;
    assign w_accept      = DEMUXN_Valid_in && w_ready;
    assign w_load        = w_target_hot & {N_OUT{w_accept}};

    always_ff @(posedge DEMUXN_CLOCK_50 or posedge DEMUXN_RESET_InHigh) begin
        if (DEMUXN_RESET_InHigh) begin
            r_ptr  <= '0;
            r_beat <= '0;
            r_wrap <= 1'b0;
        end else if (DEMUXN_Clear) begin
            r_ptr  <= '0;
            r_beat <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_accept && (DEMUXN_Mode == MODE_SEQUENTIAL)) begin
                if (r_beat == LAST_BEAT) begin
                    r_beat <= '0;
                    if (r_ptr == LAST_PTR) begin
                        r_ptr  <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_out_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .i_clk   (DEMUXN_CLOCK_50),
            .i_rst   (DEMUXN_RESET_InHigh),
            .i_clear (DEMUXN_Clear),
            .i_load  (w_load[k]),
            .i_data  (DEMUXN_Data_in),
            .i_ready (DEMUXN_Ready_in[k]),
            .o_valid (w_valid[k]),
            .o_data  (DEMUXN_Data_out[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign DEMUXN_Ready_out = w_ready;
    assign DEMUXN_Valid_out = w_valid;
    assign DEMUXN_Ptr       = r_ptr;
    assign DEMUXN_Wrap      = r_wrap;
    assign DEMUXN_SelErr    = w_sel_err;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench for demux_1_n_stream: directed scenarios followed by randomized traffic.
module tb_demux_1_n_stream;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam int BL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear, en, mode, valid_in;
    logic [SW-1:0]   sel;
    logic [DW-1:0]   data_in;
    logic [N-1:0]    ready_in;
    logic            ready_out, wrap, sel_err;
    logic [N*DW-1:0] data_out;
    logic [N-1:0]    valid_out;
    logic [SW-1:0]   ptr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-channel expected contents and count of sequential words accepted.
    logic [DW-1:0] exp_q [N][$];
    int            seq_idx = 0;
    logic          exp_wrap = 1'b0;

    demux_1_n_stream #(
        .DATA_WIDTH (DW),
        .N_OUT      (N),
        .SEL_WIDTH  (SW),
        .BURST_LEN  (BL)
    ) dut (
        .DEMUXN_CLOCK_50     (clk),
        .DEMUXN_RESET_InHigh (rst),
        .DEMUXN_Clear        (clear),
        .DEMUXN_En           (en),
        .DEMUXN_Mode         (mode),
        .DEMUXN_Sel          (sel),
        .DEMUXN_Data_in      (data_in),
        .DEMUXN_Valid_in     (valid_in),
        .DEMUXN_Ready_out    (ready_out),
        .DEMUXN_Data_out     (data_out),
        .DEMUXN_Valid_out    (valid_out),
        .DEMUXN_Ready_in     (ready_in),
        .DEMUXN_Ptr          (ptr),
        .DEMUXN_Wrap         (wrap),
        .DEMUXN_SelErr       (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT against the model at every falling edge, then advances the model
    // with whatever happens at the following rising edge.
    always @(negedge clk) begin : monitor
        int            exp_ptr, ti;
        logic          exp_sel_err, busy, exp_ready;
        logic [N-1:0]  exp_valid;
        logic [DW-1:0] exp_lane;
        if (rst) begin
            for (int k = 0; k < N; k++) exp_q[k].delete();
            seq_idx  = 0;
            exp_wrap = 1'b0;
            check("reset_valid", 64'(valid_out), 64'h0);
            check("reset_data", data_out, 64'h0);
            check("reset_ptr", 64'(ptr), 64'h0);
            check("reset_wrap", 64'(wrap), 64'h0);
        end else begin
            exp_ptr     = (seq_idx / BL) % N;
            ti          = mode ? exp_ptr : int'(sel);
            exp_sel_err = !mode && valid_in && (int'(sel) >= N);
            busy        = (ti < N) && (exp_q[ti].size() != 0) && !ready_in[ti];
            exp_ready   = en && !clear && !exp_sel_err && !busy;
            check("ready_out", 64'(ready_out), 64'(exp_ready));
            check("sel_err", 64'(sel_err), 64'(exp_sel_err));
            check("ptr", 64'(ptr), 64'(exp_ptr));
            check("wrap", 64'(wrap), 64'(exp_wrap));
            for (int k = 0; k < N; k++) begin
                exp_valid[k] = (exp_q[k].size() != 0);
                exp_lane     = exp_valid[k] ? exp_q[k][0] : '0;
                check($sformatf("lane%0d_data", k), 64'(data_out[k*DW +: DW]), 64'(exp_lane));
            end
            check("valid_out", 64'(valid_out), 64'(exp_valid));

            exp_wrap = 1'b0;
            if (clear) begin
                for (int k = 0; k < N; k++) exp_q[k].delete();
                seq_idx = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (exp_q[k].size() != 0 && ready_in[k]) void'(exp_q[k].pop_front());
                end
                if (valid_in && exp_ready) begin
                    exp_q[ti].push_back(data_in);
                    if (mode) begin
                        seq_idx++;
                        exp_wrap = (seq_idx % (N * BL)) == 0;
                    end
                end
            end
        end
    end

    initial begin
        int total;
        rst = 1'b1; clear = 1'b0; en = 1'b0; mode = 1'b0; valid_in = 1'b0;
        sel = '0; data_in = '0; ready_in = '0;
        #22 rst = 1'b0;
        step();

        // Addressed single word to lane 2.
        ready_in = 4'hF; en = 1'b1; mode = 1'b0; sel = 3'd2; data_in = 16'hA5A5; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("addr_valid", 64'(valid_out), 64'h4);
        check("addr_data", data_out, 64'hA5A5 << 32);

        // Backpressure on lane 1.
        ready_in = 4'b1101; sel = 3'd1; data_in = 16'h1111; valid_in = 1'b1;
        step();
        data_in = 16'h2222;
        #1 check("bp_ready_low", 64'(ready_out), 64'h0);
        repeat (3) begin
            step();
            check("bp_hold", 64'(data_out[DW +: DW]), 64'h1111);
        end
        ready_in = 4'hF;
        #1 check("bp_ready_high", 64'(ready_out), 64'h1);
        step();
        valid_in = 1'b0;
        check("bp_second", 64'(data_out[DW +: DW]), 64'h2222);
        step();

        // Sequential bursts of two, eight words: one full wrap.
        mode = 1'b1; valid_in = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            data_in = DW'(w);
            step();
        end
        valid_in = 1'b0;
        check("seq_wrap_pulse", 64'(wrap), 64'h1);
        check("seq_ptr_zero", 64'(ptr), 64'h0);
        valid_in = 1'b1;
        for (int w = 9; w <= 12; w++) begin
            data_in = DW'(w);
            step();
        end
        valid_in = 1'b0;
        check("seq_ptr_two", 64'(ptr), 64'h2);

        // Out-of-range select.
        mode = 1'b0; sel = 3'd5; data_in = 16'hDEAD; valid_in = 1'b1;
        #1 check("selerr_flag", 64'(sel_err), 64'h1);
        check("selerr_ready", 64'(ready_out), 64'h0);
        step();
        valid_in = 1'b0;
        check("selerr_no_load", 64'(valid_out), 64'h0);

        // Fill every slot, then clear.
        ready_in = 4'h0; valid_in = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s); data_in = 16'h5000 + DW'(s);
            step();
        end
        valid_in = 1'b0;
        check("full_valid", 64'(valid_out), 64'hF);
        check("full_ptr", 64'(ptr), 64'h2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_valid", 64'(valid_out), 64'h0);
        check("clear_data", data_out, 64'h0);
        check("clear_ptr", 64'(ptr), 64'h0);
        mode = 1'b1; ready_in = 4'hF; data_in = 16'hBEEF; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("post_clear_lane", 64'(valid_out), 64'h1);
        step();

        // Async reset between edges while slots are occupied.
        ready_in = 4'h0; valid_in = 1'b1; data_in = 16'h0101;
        step();
        data_in = 16'h0202;
        step();
        #2 rst = 1'b1;
        #1 check("arst_valid", 64'(valid_out), 64'h0);
        check("arst_data", data_out, 64'h0);
        check("arst_ptr", 64'(ptr), 64'h0);
        valid_in = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Enable low blocks acceptance.
        en = 1'b0; mode = 1'b0; sel = 3'd1; data_in = 16'h7777; valid_in = 1'b1;
        #1 check("en_low_ready", 64'(ready_out), 64'h0);
        step();
        check("en_low_no_load", 64'(valid_out), 64'h0);
        en = 1'b1; valid_in = 1'b0;

        // Randomized traffic.
        repeat (1500) begin
            mode     = ($urandom_range(0, 3) == 0) ? ~mode : mode;
            sel      = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
            valid_in = ($urandom_range(0, 9) < 7);
            data_in  = DW'($urandom);
            ready_in = N'($urandom);
            en       = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 49) == 0);
            step();
        end

        clear = 1'b0; valid_in = 1'b0; en = 1'b1; ready_in = 4'hF;
        repeat (3) step();
        total = 0;
        for (int k = 0; k < N; k++) total += exp_q[k].size();
        check("drained", 64'(total), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
